// File: rtl/cronometro_ctrl.sv
// Stopwatch control: button conditioning, start/stop/lap/clear FSM and
// display mux that chooses between the live count and a frozen lap snapshot.
module cronometro_ctrl #(
  parameter int DEB_CYCLES = 2,
  parameter int LAP_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_lap,
  input  logic [6:0]       cent_seg_in,
  input  logic [5:0]       seg_in,
  output logic             pause_out,
  output logic             clear_n_out,
  output logic [6:0]       disp_cent,
  output logic [5:0]       disp_seg,
  output logic             frozen,
  output logic [LAP_W-1:0] lap_count,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [7:0]       DEB_MAX = 8'(DEB_CYCLES);
  localparam logic [7:0]       DEB_HIT = 8'(DEB_CYCLES - 1);
  localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic       start_p;
  logic       lap_p;

  assign btn_raw = {btn_lap, btn_start};

  // Counter saturates at DEB_CYCLES, so the hit value is crossed once per press.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic       sync1_reg;
      logic       sync2_reg;
      logic [7:0] cnt_reg;
      logic       pulse_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          cnt_reg   <= 8'd0;
          pulse_reg <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (!sync2_reg)
            cnt_reg <= 8'd0;
          else if (cnt_reg != DEB_MAX)
            cnt_reg <= cnt_reg + 8'd1;
          pulse_reg <= (cnt_reg == DEB_HIT) && sync2_reg;
        end
      end

      assign btn_pulse[gi] = pulse_reg;
    end
  endgenerate

  assign start_p = btn_pulse[0];
  assign lap_p   = btn_pulse[1];

  state_t           state_reg;
  state_t           state_next;
  logic [6:0]       snap_cent_reg;
  logic [5:0]       snap_seg_reg;
  logic [LAP_W-1:0] lap_count_reg;
  logic             lap_capture;
  logic             lap_clear;

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // start_p is checked first everywhere so it wins over a coincident lap_p.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_p) state_next = RUN;
      RUN: begin
        if (start_p)    state_next = STOP;
        else if (lap_p) state_next = LAP;
      end
      LAP: begin
        if (start_p)    state_next = STOP;
        else if (lap_p) state_next = RUN;
      end
      STOP: begin
        if (start_p)    state_next = RUN;
        else if (lap_p) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pause_out   = 1'b1;
    clear_n_out = 1'b1;
    frozen      = 1'b0;
    case (state_reg)
      IDLE: clear_n_out = 1'b0;
      RUN:  pause_out   = 1'b0;
      LAP: begin
        pause_out = 1'b0;
        frozen    = 1'b1;
      end
      STOP: pause_out = 1'b1;
      default: clear_n_out = 1'b0;
    endcase
  end

  assign lap_capture = (state_reg == RUN) && (state_next == LAP);
  assign lap_clear   = (state_reg == STOP) && (state_next == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_cent_reg <= 7'd0;
      snap_seg_reg  <= 6'd0;
      lap_count_reg <= '0;
    end else if (lap_capture) begin
      snap_cent_reg <= cent_seg_in;
      snap_seg_reg  <= seg_in;
      if (lap_count_reg != LAP_MAX)
        lap_count_reg <= lap_count_reg + 1'b1;
    end else if (lap_clear) begin
      lap_count_reg <= '0;
    end
  end

  assign lap_count = lap_count_reg;
  assign state_out = state_reg;
  assign disp_cent = (state_reg == LAP) ? snap_cent_reg : cent_seg_in;
  assign disp_seg  = (state_reg == LAP) ? snap_seg_reg : seg_in;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl: debounce latency, FSM walk, lap
// capture/saturation, simultaneous presses and reset from LAP.
module tb_cronometro_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic       btn_lap;
  logic [6:0] cent_seg_in;
  logic [5:0] seg_in;
  logic       pause_out;
  logic       clear_n_out;
  logic [6:0] disp_cent;
  logic [5:0] disp_seg;
  logic       frozen;
  logic [3:0] lap_count;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;

  cronometro_ctrl #(.DEB_CYCLES(2), .LAP_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_lap     (btn_lap),
    .cent_seg_in (cent_seg_in),
    .seg_in      (seg_in),
    .pause_out   (pause_out),
    .clear_n_out (clear_n_out),
    .disp_cent   (disp_cent),
    .disp_seg    (disp_seg),
    .frozen      (frozen),
    .lap_count   (lap_count),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // state, pause, clear_n, frozen in one go
  task automatic check_ctl(input string tag, input int st, input int pa,
                           input int cl, input int fr);
    check({tag, ".state"}, int'(state_out), st);
    check({tag, ".pause"}, int'(pause_out), pa);
    check({tag, ".clear_n"}, int'(clear_n_out), cl);
    check({tag, ".frozen"}, int'(frozen), fr);
  endtask

  // Hold for n cycles, release, then let sync/debounce drain.
  task automatic press(input bit which_lap, input int n);
    if (which_lap) btn_lap = 1'b1; else btn_start = 1'b1;
    tick(n);
    btn_lap   = 1'b0;
    btn_start = 1'b0;
    tick(4);
  endtask

  initial begin
    reset       = 1'b1;
    btn_start   = 1'b0;
    btn_lap     = 1'b0;
    cent_seg_in = 7'd45;
    seg_in      = 6'd30;

    // 1: reset state
    tick(2);
    check_ctl("rst", 0, 1, 0, 0);
    check("rst.lap_count", int'(lap_count), 0);
    check("rst.disp_cent", int'(disp_cent), 45);
    check("rst.disp_seg", int'(disp_seg), 30);
    reset = 1'b0;
    tick(1);
    check("idle.state", int'(state_out), 0);

    // 2: latency and no repeat while held
    btn_start = 1'b1;
    tick(4);
    check("lat.edge4.state", int'(state_out), 0);
    tick(1);
    check_ctl("lat.edge5", 1, 0, 1, 0);
    tick(5);
    check("hold.state", int'(state_out), 1);
    btn_start = 1'b0;
    tick(4);
    check("release.state", int'(state_out), 1);
    press(1'b0, 2);
    check_ctl("stop", 3, 1, 1, 0);

    // 3: glitch rejection
    press(1'b0, 2);
    check("resume.state", int'(state_out), 1);
    press(1'b0, 1);
    check("glitch.state", int'(state_out), 1);
    press(1'b0, 2);
    check("short_ok.state", int'(state_out), 3);
    press(1'b0, 2);
    check("run_again.state", int'(state_out), 1);

    // 4: lap capture and unfreeze
    cent_seg_in = 7'd37;
    seg_in      = 6'd12;
    press(1'b1, 2);
    check_ctl("lap", 2, 0, 1, 1);
    check("lap.count", int'(lap_count), 1);
    check("lap.disp_cent", int'(disp_cent), 37);
    check("lap.disp_seg", int'(disp_seg), 12);
    cent_seg_in = 7'd80;
    seg_in      = 6'd15;
    tick(3);
    check("lapheld.disp_cent", int'(disp_cent), 37);
    check("lapheld.disp_seg", int'(disp_seg), 12);
    press(1'b1, 2);
    check_ctl("unlap", 1, 0, 1, 0);
    check("unlap.disp_cent", int'(disp_cent), 80);
    check("unlap.disp_seg", int'(disp_seg), 15);
    check("unlap.count", int'(lap_count), 1);

    // 5: stop then clear; simultaneous presses
    press(1'b0, 2);
    check("stop2.count", int'(lap_count), 1);
    press(1'b1, 2);
    check_ctl("clear", 0, 1, 0, 0);
    check("clear.count", int'(lap_count), 0);
    press(1'b0, 2);
    cent_seg_in = 7'd5;
    seg_in      = 6'd6;
    press(1'b1, 2);
    press(1'b1, 2);
    check("pre_both.count", int'(lap_count), 1);
    check("pre_both.state", int'(state_out), 1);
    cent_seg_in = 7'd99;
    seg_in      = 6'd59;
    btn_start   = 1'b1;
    btn_lap     = 1'b1;
    tick(2);
    btn_start   = 1'b0;
    btn_lap     = 1'b0;
    tick(4);
    check_ctl("both", 3, 1, 1, 0);
    check("both.count", int'(lap_count), 1);
    check("both.disp_cent", int'(disp_cent), 99);

    // 6: saturation, then reset from LAP
    press(1'b1, 2);
    press(1'b0, 2);
    check("run6.count", int'(lap_count), 0);
    for (int i = 1; i <= 16; i++) begin
      press(1'b1, 2);
      if (i == 15) check("sat15.count", int'(lap_count), 15);
      press(1'b1, 2);
    end
    check("sat16.count", int'(lap_count), 15);
    check("sat16.state", int'(state_out), 1);
    press(1'b1, 2);
    check("lapsat.state", int'(state_out), 2);
    check("lapsat.count", int'(lap_count), 15);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_ctl("rstlap", 0, 1, 0, 0);
    check("rstlap.count", int'(lap_count), 0);
    check("rstlap.disp_cent", int'(disp_cent), 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cronometro_ctrl.md
Name: cronometro_ctrl

Overview:
Control FSM for the 100 Hz stopwatch counter (centiseconds 0-99, seconds 0-59). It turns two raw push-buttons into the counter's pause and clear controls, and adds start/stop, lap-freeze and clear functions. It also drives the display path: a live value from the counter, or a frozen lap snapshot. It sits between the board buttons/displays and the counter instance, in the same clk domain.

Parameters:
DEB_CYCLES, 2, consecutive synchronized-high cycles required to accept a button press (2 = 20 ms at 100 Hz); legal range 1..255
LAP_W, 4, width of the saturating lap counter

Ports:
clk  input  1  system clock, 100 Hz, rising edge
reset  input  1  synchronous reset, active-high
btn_start  input  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  input  1  raw lap/clear button, active-high, asynchronous to clk
cent_seg_in  input  7  live centiseconds from counter
seg_in  input  6  live seconds from counter
pause_out  output  1  to counter pause input; 1 = hold count
clear_n_out  output  1  to counter clear input, active-low; 0 = force count to zero
disp_cent  output  7  centiseconds to display
disp_seg  output  6  seconds to display
frozen  output  1  1 while display shows lap snapshot
lap_count  output  LAP_W  laps taken since last clear, saturating
state_out  output  2  current FSM state encoding

Behaviour:
- Reset: one clk edge with reset=1 forces state IDLE, all sync/debounce regs 0, lap snapshot 0, lap_count 0. Applies mid-operation from any state. Outputs after reset: pause_out=1, clear_n_out=0, frozen=0, disp = live inputs, state_out=0.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter, 8 bits: increments while synced=1, saturates at DEB_CYCLES, clears to 0 when synced=0.
  - Registered pulse <= (cnt==DEB_CYCLES-1 && synced==1).
  - Result: exactly one 1-cycle pulse per press, however long the press is held.
  - Any high period shorter than DEB_CYCLES synced cycles produces no pulse.
- Latency: take the first edge at which the raw input samples 1 as edge 1. The pulse is high after edge 2+DEB_CYCLES. The state changes at edge 3+DEB_CYCLES.
- States (state_out): IDLE=0, RUN=1, LAP=2, STOP=3. Outputs are Moore, decoded from the state register.
  - IDLE: pause_out=1, clear_n_out=0. start_p -> RUN. lap_p ignored.
  - RUN: pause_out=0, clear_n_out=1. start_p -> STOP. lap_p -> LAP.
  - LAP: pause_out=0, clear_n_out=1, frozen=1. The counter keeps running. lap_p -> RUN (display live again). start_p -> STOP (display live).
  - STOP: pause_out=1, clear_n_out=1, so the count is held. start_p -> RUN (resume). lap_p -> IDLE (clear).
- Lap capture: on the RUN->LAP edge and on no other transition, the snapshot regs load cent_seg_in/seg_in as sampled at that edge. lap_count increments on the same edge and saturates at 2^LAP_W-1.
- lap_count clears to 0 on reset and on STOP->IDLE. It holds in all other transitions.
- Display mux: disp_* = snapshot when state==LAP, else cent_seg_in/seg_in, combinational pass-through.
- Simultaneous start_p and lap_p in one cycle: start_p wins and lap_p is discarded. Example: RUN with both -> STOP, no lap capture.
- No auto-repeat. Holding a button produces one event only; it must drop below DEB_CYCLES (synced 0) before it can be re-accepted.
- The block does not check input value ranges; it passes them and captures them unmodified.

Test Plan:
1. Reset held 2 cycles, buttons low, inputs 45/30 -> state_out=0, pause_out=1, clear_n_out=0, lap_count=0, frozen=0, disp=45/30.
2. DEB_CYCLES=2: btn_start high from edge 1, held 10 cycles -> state RUN at edge 5, pause_out=0, clear_n_out=1. No further transition while held. Release, press again -> STOP.
3. btn_start high for exactly 1 clk cycle in RUN -> no pulse, state stays RUN. Then a 2-cycle press -> STOP.
4. In RUN, press lap with inputs 37/12 at capture edge -> LAP, disp=37/12, frozen=1, lap_count=1. Inputs advance to 80/15 and disp stays 37/12. Second lap press -> RUN, disp=80/15.
5. RUN -> STOP -> lap press -> IDLE: clear_n_out=0, lap_count=0. Also, both buttons pulsing on the same cycle in RUN -> STOP, lap_count unchanged.
6. LAP_W=4: 16 RUN/LAP/RUN cycles -> lap_count saturates at 15. Assert reset while in LAP -> IDLE next edge, frozen=0, lap_count=0.
